// File: rtl/crc_stream_engine.sv
// crc_stream_engine: frame-aware parametrised CRC generator/checker over sop/eop-delimited beats, partial last beat, result handshake
module crc_stream_engine #(
    parameter int               DATA_W  = 32,
    parameter int               CRC_W   = 16,
    parameter logic [CRC_W-1:0] POLY    = 16'h8005,
    parameter logic [CRC_W-1:0] INIT    = '1,
    parameter logic [CRC_W-1:0] XOR_OUT = '0,
    parameter int               KEEP_W  = $clog2(DATA_W/8) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_sop,
    input  logic              in_eop,
    input  logic [KEEP_W-1:0] eop_bytes,
    input  logic [CRC_W-1:0]  exp_crc,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [CRC_W-1:0]  res_crc,
    output logic              res_match,
    output logic              proto_err,
    output logic [15:0]       frame_cnt
);
    localparam int NB = DATA_W / 8;

    typedef enum logic {IDLE, IN_FRAME} state_t;

    state_t            state_q, state_d;
    logic [CRC_W-1:0]  crc_q, crc_d, res_crc_q, res_crc_d, run, nxt;
    logic              res_valid_q, res_valid_d, res_match_q, res_match_d;
    logic              proto_err_q, proto_err_d, acc, produce;
    logic [15:0]       frame_cnt_q, frame_cnt_d;
    int                nsel;

    function automatic logic [CRC_W-1:0] crc_byte(input logic [CRC_W-1:0] c, input logic [7:0] d);
        logic [CRC_W-1:0] r;
        r = c;
        for (int j = 7; j >= 0; j--)
            r = {r[CRC_W-2:0], 1'b0} ^ ((r[CRC_W-1] ^ d[j]) ? POLY : '0);
        return r;
    endfunction

    // Unrolled byte chain; the intermediate after nsel bytes is the next state
    always_comb begin
        nsel = (in_eop && eop_bytes != '0 && int'(eop_bytes) < NB) ? int'(eop_bytes) : NB;
        run  = (in_sop || state_q == IDLE) ? INIT : crc_q;
        nxt  = run;
        for (int b = 0; b < NB; b++) begin
            run = crc_byte(run, in_data[DATA_W-1-8*b -: 8]);
            nxt = (b + 1 == nsel) ? run : nxt;
        end
    end

    assign in_ready = ~res_valid_q | res_ready;
    assign acc      = in_valid & in_ready;
    assign produce  = acc & in_eop & (in_sop | state_q == IN_FRAME);

    always_comb begin
        state_d     = state_q;
        crc_d       = crc_q;
        proto_err_d = proto_err_q;
        if (acc && (in_sop || state_q == IN_FRAME)) begin
            crc_d   = nxt;
            state_d = in_eop ? IDLE : IN_FRAME;
        end
        if (acc && (in_sop ? state_q == IN_FRAME : state_q == IDLE))
            proto_err_d = 1'b1;
        res_valid_d = produce | (res_valid_q & ~res_ready);
        res_crc_d   = produce ? nxt ^ XOR_OUT : res_crc_q;
        res_match_d = produce ? (nxt ^ XOR_OUT) == exp_crc : res_match_q;
        frame_cnt_d = frame_cnt_q + 16'(produce);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            crc_q       <= INIT;
            res_valid_q <= 1'b0;
            res_crc_q   <= '0;
            res_match_q <= 1'b0;
            proto_err_q <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            crc_q       <= crc_d;
            res_valid_q <= res_valid_d;
            res_crc_q   <= res_crc_d;
            res_match_q <= res_match_d;
            proto_err_q <= proto_err_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign res_valid = res_valid_q;
    assign res_crc   = res_crc_q;
    assign res_match = res_match_q;
    assign proto_err = proto_err_q;
    assign frame_cnt = frame_cnt_q;
endmodule

// File: doc/crc_stream_engine.md
# crc_stream_engine

Parametrised, frame-aware CRC generator/checker for the switching datapath.
- Computes a CRC of arbitrary width and polynomial over a packet stream of `DATA_W`-bit beats delimited by `sop`/`eop`.
- Handles a partial final beat, compares the result against an expected CRC, and counts completed frames.
- Sits between the ingress port buffers and the shared-cache write path.
- Generalises the fixed 32-bit-data, 16-bit-CRC engine used elsewhere in the design.

## Interface
Parameters:
- `DATA_W`, 32, beat width in bits; multiple of 8, at least 8.
- `CRC_W`, 16, CRC width in bits; range 8..32.
- `POLY`, 16'h8005, generator polynomial without the x^CRC_W term. The default is 1+x^2+x^15+x^16.
- `INIT`, all ones, CRC register value loaded at `sop`.
- `XOR_OUT`, 0, value XORed into the final CRC.
- `KEEP_W`, $clog2(DATA_W/8)+1, width of `eop_bytes`.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  beat valid.
- `in_ready`  out  1  beat accepted when `in_valid & in_ready`.
- `in_data`  in  DATA_W  beat data.
- `in_sop`  in  1  first beat of the frame.
- `in_eop`  in  1  last beat of the frame.
- `eop_bytes`  in  KEEP_W  number of valid bytes in the `eop` beat, 1..DATA_W/8; 0 means the full beat.
- `exp_crc`  in  CRC_W  expected CRC, sampled on the accepted `eop` beat.
- `res_valid`  out  1  result valid.
- `res_ready`  in  1  result accepted when `res_valid & res_ready`.
- `res_crc`  out  CRC_W  final CRC (after `XOR_OUT`).
- `res_match`  out  1  `res_crc == exp_crc`.
- `proto_err`  out  1  sticky protocol-error flag.
- `frame_cnt`  out  16  completed-frame counter.

## Operation
- Bit step, repeated for each data bit `d`:
  - `fb = crc[CRC_W-1] ^ d`
  - `crc = {crc[CRC_W-2:0],0} ^ (fb ? POLY : 0)`
- Bit order: bits are processed from bit `DATA_W-1` down to bit 0, so the MSB byte goes first.
- Full beat: all `DATA_W` steps in one cycle, implemented as an unrolled combinational loop.
- Partial `eop` beat: only the top `eop_bytes*8` bits are processed. The lower bits are ignored.
- Next-state selection: the combinational next state is chosen by a mux over the `DATA_W/8` possible byte counts.
- State machine `IDLE` / `IN_FRAME`:
  - `IDLE`, accepted beat with `sop`: the step starts from `INIT`. Go to `IN_FRAME`; if `eop` is also set, produce the result and stay in `IDLE`.
  - `IDLE`, accepted beat without `sop`: discard the beat, set `proto_err`, stay in `IDLE`.
  - `IN_FRAME`, accepted beat without `sop`: the step starts from the running CRC. `eop` produces the result and returns to `IDLE`.
  - `IN_FRAME`, accepted beat with `sop`: abandon the current frame with no result, set `proto_err`, and restart from `INIT` using this beat.
- Result production:
  - `res_crc <= next ^ XOR_OUT`, `res_match <= (next ^ XOR_OUT) == exp_crc`, `res_valid <= 1`.
  - `frame_cnt` increments by 1 and wraps 16'hFFFF→0.
- Result handshake: `res_valid` clears on `res_ready` unless a new result is produced in the same cycle. In that case the new result replaces the old one and `res_valid` stays 1.
- Backpressure: `in_ready = ~res_valid | res_ready`, a purely combinational path. While the result is blocked, no beat is accepted, so the CRC state is frozen.
- `proto_err` clears only on reset.

## Timing
- Reset values:
  - `res_valid`=0, `res_crc`=0, `res_match`=0, `proto_err`=0, `frame_cnt`=0.
  - State `IDLE`, CRC register = `INIT`.
  - `in_ready`=1.
- Latency: `res_*` are valid in the cycle after the accepted `eop` beat.
- Throughput: one beat per cycle, including back-to-back frames and consecutive single-beat (`sop&eop`) frames.
- Holding: `res_crc` and `res_match` hold while `res_valid & ~res_ready`. `in_ready` stays 0 until the result is taken.
- Unaccepted beats (`in_valid=0` or `in_ready=0`): no state change.
- `eop_bytes` is ignored on non-`eop` beats.
- Reset assertion mid-frame: the frame is abandoned, all outputs take their reset values immediately (asynchronously), and no result is produced.

## Test plan
- Defaults; "123456789" sent as 0x31323334, 0x35363738, 0x39000000 with `eop_bytes`=1 and `exp_crc`=16'hAEE7 -> `res_crc`=16'hAEE7, `res_match`=1, `frame_cnt`=1, `res_valid` rises the cycle after `eop`.
- Same frame, then a single-beat frame 0x31323334 (`sop&eop`, `eop_bytes`=0) on the next cycle with `res_ready`=1 -> two consecutive results, the second equal to the bit-serial model for "1234", `frame_cnt`=2.
- `res_ready`=0 for 5 cycles after a result -> `in_ready`=0, a beat held on input is not consumed, `res_crc` is stable; after release the next frame CRC matches the model.
- Protocol errors:
  - beat without `sop` in `IDLE` -> discarded, `proto_err`=1.
  - `sop` mid-frame -> old frame dropped, new frame CRC correct, `frame_cnt` counts only the new frame.
- `rst_n` pulsed low mid-frame -> all outputs return to reset values; the following frame matches the model; `exp_crc`=16'h0000 on a good frame -> `res_match`=0.
- Re-parametrised `DATA_W`=64, `CRC_W`=32, `POLY`=32'h04C11DB7, `INIT`=all ones, `XOR_OUT`=all ones; 1000 random frames of 1..20 beats with random `eop_bytes` and random `res_ready` stalls -> every `res_crc` equals the bit-serial model, and `frame_cnt` wraps correctly when preloaded by 65536 frames.
